// File: rtl/tag_pkg.sv
// Shared definitions for the pulse tagger: default widths, detector states and the tag record.
// With PULSE_AREA_EN defined the tag record carries the pulse area as well.
package tag_pkg;

    localparam int DEF_DW  = 14;
    localparam int DEF_TSW = 32;
    localparam int DEF_WW  = 16;
    localparam int AREA_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } tag_state_t;

    typedef struct packed {
        logic        [DEF_TSW-1:0] ts;
        logic signed [DEF_DW-1:0]  peak;
        logic        [DEF_WW-1:0]  width;
`ifdef PULSE_AREA_EN
        logic signed [AREA_W-1:0]  area;
`endif
    } tag_t;

endpackage

// File: rtl/tag_out_reg.sv
// Single-entry valid/ready holding register for tag producers; a tag offered
// while the held one is still pending is dropped and flagged in sticky ovf.
module tag_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         emit,
    input  logic [W-1:0] new_data,
    input  logic         ready,
    input  logic         ovf_clr,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         ovf
);

    logic load_s;
    logic drop_s;

    assign load_s = emit & (~valid | ready);
    assign drop_s = emit & valid & ~ready;

    // Holding register, valid flag and sticky overflow (set wins over clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= {W{1'b0}};
            ovf   <= 1'b0;
        end else begin
            if (load_s) begin
                valid <= 1'b1;
                data  <= new_data;
            end else if (ready) begin
                valid <= 1'b0;
            end else begin
                valid <= valid;
            end
            if (drop_s) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end else begin
                ovf <= ovf;
            end
        end
    end

endmodule

// File: rtl/pulse_tagger.sv
// Hysteresis pulse detector producing one (timestamp, peak, width) tag per pulse.
// Define PULSE_AREA_EN to add the tag_area output (signed sum of the counted samples).
module pulse_tagger
    import tag_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int TSW = DEF_TSW,
    parameter int WW  = DEF_WW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DW-1:0]     din,
    input  logic signed [DW-1:0]     thr_hi,
    input  logic signed [DW-1:0]     thr_lo,
    input  logic        [WW-1:0]     holdoff,
    output logic                     tag_valid,
    input  logic                     tag_ready,
    output logic        [TSW-1:0]    tag_ts,
    output logic signed [DW-1:0]     tag_peak,
    output logic        [WW-1:0]     tag_width,
`ifdef PULSE_AREA_EN
    output logic signed [AREA_W-1:0] tag_area,
`endif
    output logic                     ovf,
    input  logic                     ovf_clr
);

    tag_state_t         state_r, state_s;
    logic [TSW-1:0]     ts_r;
    logic [TSW-1:0]     start_r, start_s;
    logic signed [DW-1:0] peak_r, peak_s;
    logic [WW-1:0]      width_r, width_s;
    logic [WW-1:0]      hcnt_r, hcnt_s;
    logic               emit_s;
    tag_t               new_tag_s;
    tag_t               held_tag_s;
`ifdef PULSE_AREA_EN
    logic signed [AREA_W-1:0] area_r, area_s;
    logic signed [AREA_W-1:0] din_ext_s;

    assign din_ext_s = {{(AREA_W-DW){din[DW-1]}}, din};
`endif

    // Free-running timestamp and detector state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ts_r    <= {TSW{1'b0}};
            start_r <= {TSW{1'b0}};
            peak_r  <= {DW{1'b0}};
            width_r <= {WW{1'b0}};
            hcnt_r  <= {WW{1'b0}};
`ifdef PULSE_AREA_EN
            area_r  <= {AREA_W{1'b0}};
`endif
        end else begin
            state_r <= state_s;
            ts_r    <= ts_r + TSW'(1'b1);
            start_r <= start_s;
            peak_r  <= peak_s;
            width_r <= width_s;
            hcnt_r  <= hcnt_s;
`ifdef PULSE_AREA_EN
            area_r  <= area_s;
`endif
        end
    end

    // Next-state logic; the ending sample of a pulse is excluded from its statistics.
    always_comb begin
        state_s = state_r;
        start_s = start_r;
        peak_s  = peak_r;
        width_s = width_r;
        hcnt_s  = hcnt_r;
        emit_s  = 1'b0;
`ifdef PULSE_AREA_EN
        area_s  = area_r;
`endif
        if (!en) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = ARMED;
                end
                ARMED: begin
                    if (din > thr_hi) begin
                        state_s = PULSE;
                        start_s = ts_r;
                        peak_s  = din;
                        width_s = WW'(1'b1);
`ifdef PULSE_AREA_EN
                        area_s  = din_ext_s;
`endif
                    end else begin
                        state_s = ARMED;
                    end
                end
                PULSE: begin
                    if (din < thr_lo) begin
                        emit_s = 1'b1;
                        if (holdoff == {WW{1'b0}}) begin
                            state_s = ARMED;
                        end else begin
                            state_s = HOLD;
                            hcnt_s  = holdoff;
                        end
                    end else begin
                        if (width_r != {WW{1'b1}}) begin
                            width_s = width_r + WW'(1'b1);
                        end else begin
                            width_s = width_r;
                        end
                        if (din > peak_r) begin
                            peak_s = din;
                        end else begin
                            peak_s = peak_r;
                        end
`ifdef PULSE_AREA_EN
                        area_s = area_r + din_ext_s;
`endif
                    end
                end
                HOLD: begin
                    // Leaving on hcnt==1 re-arms exactly holdoff samples after the end sample.
                    hcnt_s = hcnt_r - WW'(1'b1);
                    if (hcnt_r <= WW'(1'b1)) begin
                        state_s = ARMED;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // Tag record offered to the holding register.
    always_comb begin
        new_tag_s       = held_tag_s;
        new_tag_s.ts    = start_r;
        new_tag_s.peak  = peak_r;
        new_tag_s.width = width_r;
`ifdef PULSE_AREA_EN
        new_tag_s.area  = area_r;
`endif
    end

    tag_out_reg #(
        .W($bits(tag_t))
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .emit     (emit_s),
        .new_data (new_tag_s),
        .ready    (tag_ready),
        .ovf_clr  (ovf_clr),
        .valid    (tag_valid),
        .data     (held_tag_s),
        .ovf      (ovf)
    );

    assign tag_ts    = held_tag_s.ts;
    assign tag_peak  = held_tag_s.peak;
    assign tag_width = held_tag_s.width;
`ifdef PULSE_AREA_EN
    assign tag_area  = held_tag_s.area;
`endif

endmodule

// File: tb/tb_pulse_tagger.sv
// Scoreboard bench for pulse_tagger: expected tags are queued as stimulus is driven
// and compared against tags captured on each valid/ready handshake.
module tb_pulse_tagger;

    typedef struct packed {
        logic        [31:0] ts;
        logic signed [13:0] peak;
        logic        [15:0] width;
    } tb_tag_t;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic signed [13:0] din;
    logic signed [13:0] thr_hi;
    logic signed [13:0] thr_lo;
    logic [15:0] holdoff;
    logic tag_valid;
    logic tag_ready;
    logic [31:0] tag_ts;
    logic signed [13:0] tag_peak;
    logic [15:0] tag_width;
    logic ovf;
    logic ovf_clr;
`ifdef PULSE_AREA_EN
    logic signed [31:0] tag_area;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] tb_ts;
    logic [31:0] ts_a;
    logic [63:0] obs;
    tb_tag_t got[$];
    tb_tag_t exp_q[$];
    tb_tag_t g, e;

    pulse_tagger dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .din       (din),
        .thr_hi    (thr_hi),
        .thr_lo    (thr_lo),
        .holdoff   (holdoff),
        .tag_valid (tag_valid),
        .tag_ready (tag_ready),
        .tag_ts    (tag_ts),
        .tag_peak  (tag_peak),
        .tag_width (tag_width),
`ifdef PULSE_AREA_EN
        .tag_area  (tag_area),
`endif
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Capture every tag that is handed over (sampled mid-cycle, away from the edge).
    always @(negedge clk) begin
        if (!rst && tag_valid && tag_ready) got.push_back({tag_ts, tag_peak, tag_width});
    end

    task automatic tick();
        @(posedge clk);
        if (rst) tb_ts = 32'd0;
        else tb_ts = tb_ts + 32'd1;
        #1;
    endtask

    task automatic drive(input logic signed [13:0] v);
        din = v;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tb_ts = 32'd0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; din = 14'sd0; thr_hi = 14'sd100; thr_lo = 14'sd50;
        holdoff = 16'd0; tag_ready = 1'b0; ovf_clr = 1'b0; tb_ts = 32'd0;
        #3;
        obs = {tag_valid, tag_ts, tag_peak, tag_width, ovf};
        total++;
        if (obs !== 64'd0) begin bad++; $display("FAIL reset_initial got=%h want=0", obs); end
        tick();
        rst = 1'b0;
        en = 1'b1;
        drive(14'sd0);
        drive(14'sd200); drive(14'sd40);
        drive(14'sd200); drive(14'sd40);
        drive(14'sd200); drive(14'sd200); drive(14'sd200);
        total++;
        if ({tag_valid, ovf} !== 2'b11) begin bad++; $display("FAIL reset_precond got valid,ovf=%b want=11", {tag_valid, ovf}); end
        rst = 1'b1;
        #1;
        obs = {tag_valid, tag_ts, tag_peak, tag_width, ovf};
        total++;
        if (obs !== 64'd0) begin bad++; $display("FAIL reset_midpulse got=%h want=0", obs); end
        tick();
        rst = 1'b0;
        tb_ts = 32'd0;
        tag_ready = 1'b1;
        drive(14'sd200); drive(14'sd40); drive(14'sd40); drive(14'sd0);
        total++;
        if (tag_valid !== 1'b0 || got.size() !== 0) begin
            bad++; $display("FAIL reset_notag got valid=%b tags=%0d want valid=0 tags=0", tag_valid, got.size());
        end
        got.delete();
    endtask

    task automatic test_basic();
        do_reset();
        tag_ready = 1'b1; holdoff = 16'd0;
        for (int i = 0; i < 50 && tb_ts != 32'd10; i++) drive(14'sd0);
        exp_q.push_back({32'd10, 14'sd300, 16'd3});
        drive(14'sd150); drive(14'sd300); drive(14'sd120);
        total++;
        if (tag_valid !== 1'b0) begin bad++; $display("FAIL basic_early got=%b want=0", tag_valid); end
        drive(14'sd40);
        total++;
        if (tag_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b want=1", tag_valid); end
        drive(14'sd0);
        total++;
        if (tag_valid !== 1'b0) begin bad++; $display("FAIL basic_consumed got=%b want=0", tag_valid); end
        drive(14'sd0);
        total++;
        if (got.size() !== exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d want=%0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            g = got.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL basic_tag got ts=%h peak=%0d width=%0d want ts=%h peak=%0d width=%0d", g.ts, g.peak, g.width, e.ts, e.peak, e.width); end
        end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_holdoff();
        holdoff = 16'd4; tag_ready = 1'b1;
        exp_q.push_back({tb_ts, 14'sd200, 16'd2});
        drive(14'sd150); drive(14'sd200); drive(14'sd40);
        // Second pulse falls entirely inside the four blanked samples.
        drive(14'sd0); drive(14'sd0); drive(14'sd150); drive(14'sd150); drive(14'sd0);
        exp_q.push_back({tb_ts, 14'sd170, 16'd2});
        drive(14'sd150); drive(14'sd170); drive(14'sd40);
        for (int i = 0; i < 4; i++) drive(14'sd0);
        exp_q.push_back({tb_ts, 14'sd180, 16'd2});
        drive(14'sd180); drive(14'sd60); drive(14'sd40);
        for (int i = 0; i < 6; i++) drive(14'sd0);
        total++;
        if (got.size() !== exp_q.size()) begin bad++; $display("FAIL holdoff_count got=%0d want=%0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            g = got.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL holdoff_tag got ts=%h peak=%0d width=%0d want ts=%h peak=%0d width=%0d", g.ts, g.peak, g.width, e.ts, e.peak, e.width); end
        end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        holdoff = 16'd0; tag_ready = 1'b0;
        ts_a = tb_ts;
        drive(14'sd150); drive(14'sd250); drive(14'sd40);
        obs = {tag_valid, tag_ts, tag_peak, tag_width, ovf};
        total++;
        if (obs !== {1'b1, ts_a, 14'sd250, 16'd2, 1'b0}) begin bad++; $display("FAIL bp_first got=%h want=%h", obs, {1'b1, ts_a, 14'sd250, 16'd2, 1'b0}); end
        drive(14'sd160); drive(14'sd170);
        ovf_clr = 1'b1;
        drive(14'sd30);
        ovf_clr = 1'b0;
        obs = {tag_valid, tag_ts, tag_peak, tag_width, ovf};
        total++;
        if (obs !== {1'b1, ts_a, 14'sd250, 16'd2, 1'b1}) begin bad++; $display("FAIL bp_drop got=%h want=%h", obs, {1'b1, ts_a, 14'sd250, 16'd2, 1'b1}); end
        drive(14'sd0);
        total++;
        if (ovf !== 1'b1) begin bad++; $display("FAIL bp_sticky got=%b want=1", ovf); end
        ovf_clr = 1'b1;
        drive(14'sd0);
        ovf_clr = 1'b0;
        total++;
        if (ovf !== 1'b0) begin bad++; $display("FAIL bp_clear got=%b want=0", ovf); end
        exp_q.push_back({ts_a, 14'sd250, 16'd2});
        tag_ready = 1'b1;
        drive(14'sd0);
        total++;
        if (tag_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", tag_valid); end
        drive(14'sd0);
        total++;
        if (got.size() !== exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            g = got.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL bp_tag got ts=%h peak=%0d width=%0d want ts=%h peak=%0d width=%0d", g.ts, g.peak, g.width, e.ts, e.peak, e.width); end
        end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        holdoff = 16'd0; tag_ready = 1'b1;
        din = -14'sd300; thr_hi = -14'sd100; thr_lo = -14'sd200;
        tick();
        exp_q.push_back({tb_ts, -14'sd50, 16'hFFFF});
        for (int i = 0; i < 70000; i++) drive(-14'sd50);
        drive(-14'sd300); drive(-14'sd300);
        din = 14'sd0; thr_hi = 14'sd100; thr_lo = 14'sd50;
        tick();
        total++;
        if (got.size() !== exp_q.size()) begin bad++; $display("FAIL sat_count got=%0d want=%0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            g = got.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL sat_tag got ts=%h peak=%0d width=%0d want ts=%h peak=%0d width=%0d", g.ts, g.peak, g.width, e.ts, e.peak, e.width); end
        end
        got.delete(); exp_q.delete();
    endtask

    task automatic test_enable_wrap();
        tag_ready = 1'b1; holdoff = 16'd0;
        drive(14'sd150); drive(14'sd200);
        en = 1'b0;
        drive(14'sd200);
        en = 1'b1;
        drive(14'sd40); drive(14'sd40); drive(14'sd0);
        total++;
        if (tag_valid !== 1'b0 || got.size() !== 0) begin
            bad++; $display("FAIL abort got valid=%b tags=%0d want valid=0 tags=0", tag_valid, got.size());
        end
        got.delete();
        force dut.ts_r = 32'hFFFF_FFFE;
        #2;
        release dut.ts_r;
        tb_ts = 32'hFFFF_FFFE;
        drive(14'sd0);
        exp_q.push_back({32'hFFFF_FFFF, 14'sd200, 16'd2});
        drive(14'sd150); drive(14'sd200); drive(14'sd40);
        exp_q.push_back({32'd2, 14'sd180, 16'd1});
        drive(14'sd180); drive(14'sd40); drive(14'sd0); drive(14'sd0);
        total++;
        if (got.size() !== exp_q.size()) begin bad++; $display("FAIL wrap_count got=%0d want=%0d", got.size(), exp_q.size()); end
        while (got.size() > 0 && exp_q.size() > 0) begin
            g = got.pop_front(); e = exp_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL wrap_tag got ts=%h peak=%0d width=%0d want ts=%h peak=%0d width=%0d", g.ts, g.peak, g.width, e.ts, e.peak, e.width); end
        end
        got.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_holdoff();
        test_back_to_back();
        test_saturation();
        test_enable_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_tagger.md
Name: pulse_tagger

Overview:
Downstream consumer of the tag-path programmable sample delay line. It watches the delayed 14-bit signed ADC stream for pulses using a two-threshold (hysteresis) detector. For each completed pulse it emits one tag (start timestamp, peak, width) on a valid/ready interface toward the tag FIFO / AXI readout. A programmable holdoff blanks re-triggering after each pulse.

Parameters:
DW, 14, sample width (signed two's complement)
TSW, 32, timestamp counter width
WW, 16, pulse-width and holdoff counter width

Ports:
clk  in  1  sample clock, one sample per cycle
rst  in  1  asynchronous, active-high reset
en  in  1  detector enable; 0 forces IDLE
din  in  DW  delayed sample from the delay line, signed
thr_hi  in  DW  arm-to-pulse threshold, signed
thr_lo  in  DW  pulse-end threshold, signed; software keeps thr_lo <= thr_hi
holdoff  in  WW  blanking cycles after each pulse end
tag_valid  out  1  tag available
tag_ready  in  1  consumer accepts tag
tag_ts  out  TSW  timestamp of first sample above thr_hi
tag_peak  out  DW  maximum signed sample within the pulse
tag_width  out  WW  pulse length in samples, saturating
ovf  out  1  sticky: a tag was dropped
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (async): state=IDLE. ts counter, tag_valid, tag_ts, tag_peak, tag_width, ovf and all internal registers = 0.
- Timestamp: free-running TSW-bit counter, +1 every cycle independent of en. Wraps all-ones -> 0 with no flag.
- All comparisons are signed. "Above" means din > thr_hi (strict). "End" means din < thr_lo (strict).
- FSM:
  - IDLE: entered when en=0. Moves to ARMED on the first cycle en=1.
  - ARMED: if din > thr_hi, capture ts_start=ts, peak=din, width=1, go to PULSE.
  - PULSE:
    - If din < thr_lo: emit tag with the current peak and width (the ending sample is not counted), then go to HOLD with hcnt=holdoff, or directly to ARMED if holdoff=0.
    - Otherwise: width=width+1, saturating at all-ones; if din > peak then peak=din.
  - HOLD: hcnt decrements each cycle. On the cycle hcnt=1 go to ARMED, so ARMED is active exactly holdoff cycles after the end sample. The detector ignores din while in HOLD.
  - en=0 in any state: go to IDLE next cycle. A pulse in progress is aborted with no tag. An already-registered tag is unaffected.
- Latency: tag_valid rises on the clock edge that samples the end sample (1-cycle registered output). tag_ts equals the ts value on the edge that sampled the first above-threshold sample.
- Output register, single entry:
  - Load when an emit occurs and (tag_valid=0 or tag_ready=1).
  - Emit + tag_valid=1 + tag_ready=0: new tag dropped, ovf=1, held tag unchanged.
  - Emit + accept in the same cycle: new tag loaded, tag_valid stays 1.
  - tag_ready=1 with no emit: tag_valid=0.
  - Outputs stay stable while tag_valid=1 and tag_ready=0.
- ovf: set has priority over ovf_clr in the same cycle.
- A pulse is never lost to holdoff=0: back-to-back pulses are re-armed on the cycle after the end sample.

Optional Feature:
PULSE_AREA_EN
- Defined: adds output tag_area (out, 32 bits), the wrapping signed sum of sign-extended din over the counted pulse samples (same samples as tag_width). It is registered and held together with the other tag fields. Reset value is 0.
- Undefined: the port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Shared package tag_pkg: DW/TSW/WW defaults, state typedef {IDLE, ARMED, PULSE, HOLD}, and tag struct {ts, peak, width[, area]}.
- One sub-module, tag_out_reg: the single-entry valid/ready holding register with drop/ovf logic, reusable by other tag producers.

Test Plan:
- Reset mid-pulse: en=1, thr_hi=100, thr_lo=50, din=200 for 3 cycles, then assert rst -> all outputs 0, state IDLE, no tag after release.
- Basic pulse: holdoff=0, ready=1, din sequence 0,150,300,120,40 with ts=10 at the 150 sample -> one tag: ts=10, peak=300, width=3; tag_valid on the edge sampling 40.
- Holdoff: holdoff=4, two pulses separated by 2 below-threshold cycles -> second pulse ignored. Pulses separated by 4 cycles -> second tag emitted.
- Backpressure: tag_ready=0, two pulses -> first tag held unchanged, second dropped, ovf=1. Simultaneous ovf_clr on the set cycle -> ovf stays 1. A later ovf_clr alone -> 0.
- Negative/saturation: thr_hi=-100, thr_lo=-200, din=-50 held 70000 cycles then -300 -> tag_width=65535, peak=-50.
- Enable abort and timestamp wrap: drop en mid-pulse -> no tag. Start a pulse at ts=0xFFFFFFFF -> tag_ts=0xFFFFFFFF.
